// File: rtl/mapper_rr_sched_if.sv
// Handshake bundle for mapper_rr_sched: two operand request ports and one tagged result port.
// master = requesters/consumer side, slave = scheduler side.
interface mapper_rr_sched_if #(parameter int nbits = 32);
  logic               req0_val;
  logic               req0_rdy;
  logic [4*nbits-1:0] req0_msg;
  logic               req1_val;
  logic               req1_rdy;
  logic [4*nbits-1:0] req1_msg;
  logic               resp_val;
  logic               resp_rdy;
  logic [nbits-1:0]   resp_msg;
  logic               resp_id;

  modport master (
    output req0_val, req0_msg, req1_val, req1_msg, resp_rdy,
    input  req0_rdy, req1_rdy, resp_val, resp_msg, resp_id
  );

  modport slave (
    input  req0_val, req0_msg, req1_val, req1_msg, resp_rdy,
    output req0_rdy, req1_rdy, resp_val, resp_msg, resp_id
  );
endinterface

// File: rtl/mapper_rr_sched.sv
// Round-robin sharing of one multiply-add mapper (in0*in1 + in2*in3) between two requesters.
// Optional MAPPER_SCHED_PERF_EN adds a saturating conflict_cnt output.
module mapper_mul_lane #(parameter int nbits = 32) (
  input  logic [nbits-1:0] a,
  input  logic [nbits-1:0] b,
  output logic [nbits-1:0] p
);
  assign p = a * b;
endmodule

module mapper_rr_sched #(parameter int nbits = 32) (
  input  logic               clk,
  input  logic               reset,
  mapper_rr_sched_if.slave   bus
`ifdef MAPPER_SCHED_PERF_EN
  ,
  output logic [31:0]        conflict_cnt
`endif
);
  localparam int NUM_LANES = 2;

  logic                            last_grant;
  logic                            resp_val_q;
  logic [nbits-1:0]                resp_msg_q;
  logic                            resp_id_q;
  logic                            space;
  logic                            grant0;
  logic                            grant1;
  logic                            rdy0;
  logic                            rdy1;
  logic                            xfer;
  logic [2*NUM_LANES-1:0][nbits-1:0] opnd;
  logic [NUM_LANES-1:0][nbits-1:0]   prod;
  logic [nbits-1:0]                sum;

  // last_grant==1 means req0 wins a tie, and vice versa
  assign space  = !resp_val_q || bus.resp_rdy;
  assign grant0 = bus.req0_val && (!bus.req1_val || last_grant);
  assign grant1 = bus.req1_val && (!bus.req0_val || !last_grant);
  assign rdy0   = grant0 && space && !reset;
  assign rdy1   = grant1 && space && !reset;
  assign xfer   = rdy0 || rdy1;

  assign opnd = grant1 ? bus.req1_msg : bus.req0_msg;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    mapper_mul_lane #(.nbits(nbits)) u_lane (
      .a (opnd[2*i]),
      .b (opnd[2*i+1]),
      .p (prod[i])
    );
  end

  assign sum = prod[0] + prod[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_val_q <= 1'b0;
      resp_msg_q <= '0;
      resp_id_q  <= 1'b0;
      last_grant <= 1'b1;
    end else if (xfer) begin
      resp_val_q <= 1'b1;
      resp_msg_q <= sum;
      resp_id_q  <= rdy1;
      last_grant <= rdy1;
    end else if (bus.resp_rdy) begin
      resp_val_q <= 1'b0;
    end
  end

`ifdef MAPPER_SCHED_PERF_EN
  logic [31:0] conflict_q;
  always_ff @(posedge clk) begin
    if (reset)
      conflict_q <= '0;
    else if (bus.req0_val && bus.req1_val && xfer && conflict_q != 32'hFFFF_FFFF)
      conflict_q <= conflict_q + 32'd1;
  end
  assign conflict_cnt = conflict_q;
`endif

  assign bus.req0_rdy = rdy0;
  assign bus.req1_rdy = rdy1;
  assign bus.resp_val = resp_val_q;
  assign bus.resp_msg = resp_msg_q;
  assign bus.resp_id  = resp_id_q;
endmodule

// File: tb/tb_mapper_rr_sched.sv
// Bench for mapper_rr_sched: constant vector table, hand sequences, then random traffic vs a transaction model.
module tb_mapper_rr_sched;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mapper_rr_sched_if #(.nbits(32)) bus ();
`ifdef MAPPER_SCHED_PERF_EN
  logic [31:0] conflict_cnt;
`endif

  mapper_rr_sched #(.nbits(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef MAPPER_SCHED_PERF_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // transaction-level model of the scheduler
  logic        m_val;
  logic [31:0] m_msg;
  logic        m_id;
  int          m_last;
  longint      m_cnt;

  localparam logic [127:0] M42   = {32'd6, 32'd5, 32'd4, 32'd3};
  localparam logic [127:0] MWRAP = {32'd5, 32'd1, 32'h0001_0000, 32'h0001_0000};
  localparam logic [127:0] M8    = {4{32'd2}};
  localparam logic [127:0] M2    = {4{32'd1}};
  localparam logic [127:0] MMAX  = {4{32'hFFFF_FFFF}};

  typedef struct {
    logic         v0;
    logic [127:0] m0;
    logic         v1;
    logic [127:0] m1;
    logic         rr;
    logic         e_rdy0;
    logic         e_rdy1;
    logic         e_val;
    logic [31:0]  e_msg;
    logic         e_id;
  } vec_t;

  vec_t tbl[13];

  function automatic logic [31:0] madd(input logic [127:0] m);
    longint unsigned a, b, c, d;
    a = longint'(m[31:0]);
    b = longint'(m[63:32]);
    c = longint'(m[95:64]);
    d = longint'(m[127:96]);
    return 32'((a * b + c * d) % 64'h1_0000_0000);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_val  = 1'b0;
    m_msg  = '0;
    m_id   = 1'b0;
    m_last = 1;
    m_cnt  = 0;
  endtask

  // one clock: drive, check rdy before the edge, check outputs after it
  task automatic step(input logic rst, input logic v0, input logic [127:0] m0,
                      input logic v1, input logic [127:0] m1, input logic rr,
                      output logic r0, output logic r1);
    int  winner;
    bit  take;
    @(negedge clk);
    reset        = rst;
    bus.req0_val = v0;
    bus.req0_msg = m0;
    bus.req1_val = v1;
    bus.req1_msg = m1;
    bus.resp_rdy = rr;
    #1;
    r0 = bus.req0_rdy;
    r1 = bus.req1_rdy;
    if (v0 && v1)  winner = (m_last == 0) ? 1 : 0;
    else if (v0)   winner = 0;
    else if (v1)   winner = 1;
    else           winner = -1;
    take = !rst && winner >= 0 && (!m_val || rr);
    chk("model_rdy0", {31'd0, r0}, {31'd0, take && winner == 0});
    chk("model_rdy1", {31'd0, r1}, {31'd0, take && winner == 1});
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else if (take) begin
      m_val  = 1'b1;
      m_msg  = madd(winner == 1 ? m1 : m0);
      m_id   = (winner == 1);
      m_last = winner;
      if (v0 && v1 && m_cnt < 64'hFFFF_FFFF) m_cnt++;
    end else if (rr) begin
      m_val = 1'b0;
    end
    chk("model_resp_val", {31'd0, bus.resp_val}, {31'd0, m_val});
    chk("model_resp_msg", bus.resp_msg, m_msg);
    chk("model_resp_id",  {31'd0, bus.resp_id}, {31'd0, m_id});
  endtask

  initial begin
    logic r0, r1;
    logic v0, v1, rr, rst;
    logic [127:0] m0, m1;

    tbl[0]  = '{1'b1, M42,  1'b0, '0,   1'b1, 1'b1, 1'b0, 1'b1, 32'd42, 1'b0};
    tbl[1]  = '{1'b0, '0,   1'b1, MWRAP,1'b1, 1'b0, 1'b1, 1'b1, 32'd5,  1'b1};
    tbl[2]  = '{1'b0, '0,   1'b0, '0,   1'b1, 1'b0, 1'b0, 1'b0, 32'd5,  1'b1};
    tbl[3]  = '{1'b1, M8,   1'b1, M2,   1'b1, 1'b1, 1'b0, 1'b1, 32'd8,  1'b0};
    tbl[4]  = '{1'b1, M8,   1'b1, M2,   1'b0, 1'b0, 1'b0, 1'b1, 32'd8,  1'b0};
    tbl[5]  = '{1'b1, M8,   1'b1, M2,   1'b0, 1'b0, 1'b0, 1'b1, 32'd8,  1'b0};
    tbl[6]  = '{1'b1, M8,   1'b1, M2,   1'b0, 1'b0, 1'b0, 1'b1, 32'd8,  1'b0};
    tbl[7]  = '{1'b1, M8,   1'b1, M2,   1'b1, 1'b0, 1'b1, 1'b1, 32'd2,  1'b1};
    tbl[8]  = '{1'b1, M8,   1'b1, M2,   1'b1, 1'b1, 1'b0, 1'b1, 32'd8,  1'b0};
    tbl[9]  = '{1'b1, M8,   1'b1, M2,   1'b1, 1'b0, 1'b1, 1'b1, 32'd2,  1'b1};
    tbl[10] = '{1'b1, M8,   1'b0, '0,   1'b1, 1'b1, 1'b0, 1'b1, 32'd8,  1'b0};
    tbl[11] = '{1'b1, MMAX, 1'b0, '0,   1'b1, 1'b1, 1'b0, 1'b1, 32'd2,  1'b0};
    tbl[12] = '{1'b0, '0,   1'b1, M2,   1'b0, 1'b0, 1'b0, 1'b1, 32'd2,  1'b0};

    reset = 1'b1;
    bus.req0_val = 1'b0; bus.req0_msg = '0;
    bus.req1_val = 1'b0; bus.req1_msg = '0;
    bus.resp_rdy = 1'b0;
    model_reset();

    // reset with both requesters valid: no rdy, outputs at reset values
    step(1'b1, 1'b1, M8, 1'b1, M2, 1'b1, r0, r1);
    chk("rst_rdy0", {31'd0, r0}, 32'd0);
    chk("rst_rdy1", {31'd0, r1}, 32'd0);
    chk("rst_resp_val", {31'd0, bus.resp_val}, 32'd0);
    chk("rst_resp_msg", bus.resp_msg, 32'd0);

    for (int i = 0; i < 13; i++) begin
      step(1'b0, tbl[i].v0, tbl[i].m0, tbl[i].v1, tbl[i].m1, tbl[i].rr, r0, r1);
      chk($sformatf("tbl%0d_rdy0", i), {31'd0, r0}, {31'd0, tbl[i].e_rdy0});
      chk($sformatf("tbl%0d_rdy1", i), {31'd0, r1}, {31'd0, tbl[i].e_rdy1});
      chk($sformatf("tbl%0d_val", i),  {31'd0, bus.resp_val}, {31'd0, tbl[i].e_val});
      chk($sformatf("tbl%0d_msg", i),  bus.resp_msg, tbl[i].e_msg);
      chk($sformatf("tbl%0d_id", i),   {31'd0, bus.resp_id}, {31'd0, tbl[i].e_id});
    end

    // slot is full here; reset discards it and restores req0 priority
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, r0, r1);
    chk("rst2_resp_val", {31'd0, bus.resp_val}, 32'd0);
    chk("rst2_resp_id",  {31'd0, bus.resp_id}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, M42, 1'b1, MWRAP, 1'b1, r0, r1);
      chk($sformatf("alt%0d_rdy0", i), {31'd0, r0}, {31'd0, (i % 2) == 0});
      chk($sformatf("alt%0d_rdy1", i), {31'd0, r1}, {31'd0, (i % 2) == 1});
      chk($sformatf("alt%0d_id", i),   {31'd0, bus.resp_id}, 32'(i % 2));
      chk($sformatf("alt%0d_msg", i),  bus.resp_msg, (i % 2) == 0 ? 32'd42 : 32'd5);
    end
`ifdef MAPPER_SCHED_PERF_EN
    chk("conflict_cnt_10", conflict_cnt, 32'd10);
`endif

    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      v0  = $urandom_range(0, 2) != 0;
      v1  = $urandom_range(0, 2) != 0;
      rr  = $urandom_range(0, 3) != 0;
      m0  = {$urandom, $urandom, $urandom, $urandom};
      m1  = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) == 0) m0 = m0 & {4{32'h0000_00FF}};
      step(rst, v0, m0, v1, m1, rr, r0, r1);
`ifdef MAPPER_SCHED_PERF_EN
      chk("model_conflict_cnt", conflict_cnt, 32'(m_cnt));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
